pipe_stage_reg: RTL and testbench

- Parametrised, flow-controlled pipeline stage register; next generation of the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Carries one packed payload bus of WIDTH bits using a valid/ready handshake and a 2-entry skid buffer.
- Downstream back-pressure therefore never creates a combinational ready path upstream.
- Adds synchronous reset and a flush for branch/jump squash. Sits between any two CPU stages.

---
 rtl/pipe_stage_reg.sv | 93 +++++++++
 tb/tb_pipe_stage_reg.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with 2-entry skid buffer and flush
// Optional perf counters (stall_cnt, flush_cnt) enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             drain;

  // Handshake outputs come straight from state, so ready_in never reaches ready_out.
  assign valid_out = (state != ST_EMPTY);
  assign ready_out = (state != ST_TWO);
  assign data_out  = main_q;

  assign accept = valid_in & ready_out;
  assign drain  = valid_out & ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state  <= ST_ONE;
            main_q <= data_in;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_q <= data_in;
          end else if (drain) begin
            state <= ST_EMPTY;
          end else if (accept) begin
            state  <= ST_TWO;
            skid_q <= data_in;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state  <= ST_ONE;
            main_q <= skid_q;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (valid_out && !ready_in && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - table-driven and scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, valid_in, ready_in;
  logic [31:0] data_in;
  logic        ready_out, valid_out;
  logic [31:0] data_out;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic        r, f, v;
    logic [31:0] d;
    logic        rdy;
    logic        ev, er;
    logic [31:0] ed;
  } vec_t;

  vec_t        vecs[22];
  logic [31:0] sb[$];
  int          checks = 0;
  int          failures = 0;
  bit          armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle; the queue tracks accepted payloads and so the stage occupancy.
  task automatic step(input logic r, input logic f, input logic v, input logic [31:0] d, input logic rdy);
    logic [31:0] exp_d;
    rst = r; flush = f; valid_in = v; data_in = d; ready_in = rdy;
    #1;
    if (armed) begin
      check("occ_valid", 32'(valid_out), 32'(sb.size() != 0));
      check("occ_ready", 32'(ready_out), 32'(sb.size() < 2));
      if (valid_out && rdy) begin
        if (sb.size() == 0) begin
          check("spurious_out", 32'(valid_out), 32'd0);
        end else begin
          exp_d = sb.pop_front();
          check("order", data_out, exp_d);
        end
      end
    end
    if (r || f) sb.delete();
    else if (v && ready_out) sb.push_back(d);
    @(posedge clk);
    @(negedge clk);
    armed = 1'b1;
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic v, input logic [31:0] d,
                              input logic rdy, input logic ev, input logic er, input logic [31:0] ed);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.d = d; t.rdy = rdy; t.ev = ev; t.er = er; t.ed = ed;
    return t;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = '0;
    //              r     f     v     data           rdy   ev    er    exp data
    vecs[0]  = mk(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, 32'h1,         1'b1, 1'b1, 1'b1, 32'h1);
    vecs[3]  = mk(1'b0, 1'b0, 1'b1, 32'h2,         1'b1, 1'b1, 1'b1, 32'h2);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 32'h3,         1'b1, 1'b1, 1'b1, 32'h3);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 32'h4,         1'b1, 1'b1, 1'b1, 32'h4);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h4);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 32'hA0,        1'b1, 1'b1, 1'b1, 32'hA0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 32'hA1,        1'b0, 1'b1, 1'b0, 32'hA0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 32'hA2,        1'b0, 1'b1, 1'b0, 32'hA0);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 32'hA2,        1'b1, 1'b1, 1'b1, 32'hA1);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 32'hA2,        1'b1, 1'b1, 1'b1, 32'hA2);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hA2);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 32'h10,        1'b0, 1'b1, 1'b1, 32'h10);
    vecs[14] = mk(1'b0, 1'b0, 1'b1, 32'h11,        1'b0, 1'b1, 1'b0, 32'h10);
    vecs[15] = mk(1'b0, 1'b1, 1'b1, 32'h12,        1'b0, 1'b0, 1'b1, 32'h10);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h10);
    vecs[17] = mk(1'b0, 1'b1, 1'b1, 32'h55,        1'b1, 1'b0, 1'b1, 32'h10);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h10);
    vecs[19] = mk(1'b0, 1'b0, 1'b1, 32'h77,        1'b0, 1'b1, 1'b1, 32'h77);
    vecs[20] = mk(1'b1, 1'b1, 1'b1, 32'h78,        1'b0, 1'b0, 1'b1, 32'h0);
    vecs[21] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0);

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].d, vecs[i].rdy);
      check($sformatf("vec%0d_valid_out", i), 32'(valid_out), 32'(vecs[i].ev));
      check($sformatf("vec%0d_ready_out", i), 32'(ready_out), 32'(vecs[i].er));
      check($sformatf("vec%0d_data_out", i), data_out, vecs[i].ed);
    end

`ifdef PIPE_STAGE_PERF_EN
    check("perf_rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("perf_rst_stall_cnt", stall_cnt, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h99, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("perf_stall_cnt", stall_cnt, 32'd5);
    check("perf_flush_cnt", 32'(flush_cnt), 32'd1);
`endif

    // Random traffic with occasional flush; scoreboard checks order and occupancy.
    for (int i = 0; i < 400; i++) begin
      step(1'b0, ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), $urandom,
           ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("final_empty", 32'(sb.size()), 32'd0);
    check("final_valid_out", 32'(valid_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
